// File: rtl/gtx_8b10b_pkg.sv
// Shared definitions for the GTX 10b/8b decode path: lane widths, K28.5
// reference codes, running-disparity type and a small popcount helper.
package gtx_8b10b_pkg;

    localparam int SYM_W  = 10;
    localparam int BYTE_W = 8;

    localparam logic [SYM_W-1:0] K28_5_NEG = 10'h17C;
    localparam logic [SYM_W-1:0] K28_5_POS = 10'h283;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_t;

    function automatic logic [3:0] popcount(input logic [SYM_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dec_10b8b_sym.sv
// Combinational single-symbol 10b/8b decoder with running-disparity step.
// Bit order: symbol[0]=a ... symbol[5]=i, symbol[6]=f ... symbol[9]=j.
module dec_10b8b_sym
    import gtx_8b10b_pkg::*;
(
    input  logic [SYM_W-1:0]  symbol,
    input  rd_t               rd_in,
    output logic [BYTE_W-1:0] data,
    output logic              isk,
    output logic              invalid,
    output logic              disperr,
    output rd_t               rd_out
);

    logic [5:0] s6;     // abcdei, a in MSB so literals read like the code tables
    logic [3:0] f4;     // fghj, f in MSB
    logic [3:0] ones6;
    logic [3:0] ones4;
    logic [3:0] ones10;

    assign s6     = {symbol[0], symbol[1], symbol[2], symbol[3], symbol[4], symbol[5]};
    assign f4     = {symbol[6], symbol[7], symbol[8], symbol[9]};
    assign ones6  = popcount({4'b0000, s6});
    assign ones4  = popcount({6'b000000, f4});
    assign ones10 = popcount(symbol);

    logic [4:0] x;
    logic       v6;
    logic       k28;

    // 5b/6b subblock lookup (both disparity columns)
    always_comb begin
        x   = '0;
        v6  = 1'b1;
        k28 = 1'b0;
        case (s6)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110:            x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            6'b001111, 6'b110000: begin x = 5'd28; k28 = 1'b1; end
            default:              v6 = 1'b0;
        endcase
    end

    logic [2:0] yd;
    logic       v4;

    // 3b/4b data subblock lookup
    always_comb begin
        yd = '0;
        v4 = 1'b1;
        case (f4)
            4'b1011, 4'b0100:                   yd = 3'd0;
            4'b1001:                            yd = 3'd1;
            4'b0101:                            yd = 3'd2;
            4'b1100, 4'b0011:                   yd = 3'd3;
            4'b1101, 4'b0010:                   yd = 3'd4;
            4'b1010:                            yd = 3'd5;
            4'b0110:                            yd = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: yd = 3'd7;
            default:                            v4 = 1'b0;
        endcase
    end

    logic [2:0] yk;
    logic       vk;

    // K28 3b/4b lookup; the column depends on which K28 6b form preceded it
    always_comb begin
        yk = '0;
        vk = 1'b1;
        if (ones6 == 4'd4) begin
            case (f4)
                4'b0100: yk = 3'd0;
                4'b1001: yk = 3'd1;
                4'b0101: yk = 3'd2;
                4'b0011: yk = 3'd3;
                4'b0010: yk = 3'd4;
                4'b1010: yk = 3'd5;
                4'b0110: yk = 3'd6;
                4'b1000: yk = 3'd7;
                default: vk = 1'b0;
            endcase
        end else begin
            case (f4)
                4'b1011: yk = 3'd0;
                4'b0110: yk = 3'd1;
                4'b1010: yk = 3'd2;
                4'b1100: yk = 3'd3;
                4'b1101: yk = 3'd4;
                4'b0101: yk = 3'd5;
                4'b1001: yk = 3'd6;
                4'b0111: yk = 3'd7;
                default: vk = 1'b0;
            endcase
        end
    end

    // The 6b subblock fixes the disparity seen by the 4b subblock unless it
    // is balanced (D.07 forms are balanced but still column-specific).
    logic mid_pos, mid_neg, need_pos, need_neg;
    logic x_a7n, x_a7p, a7_ok, data_ok, kx7;

    assign mid_pos  = (ones6 == 4'd4) || (s6 == 6'b000111);
    assign mid_neg  = (ones6 == 4'd2) || (s6 == 6'b111000);
    assign need_neg = (ones4 == 4'd3) || (f4 == 4'b1100);
    assign need_pos = (ones4 == 4'd1) || (f4 == 4'b0011);
    assign x_a7n    = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    assign x_a7p    = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);

    // D.x.A7 replaces D.x.P7 only for the x values that would otherwise run long
    always_comb begin
        case (f4)
            4'b0111: a7_ok = x_a7n;
            4'b1000: a7_ok = x_a7p;
            4'b1110: a7_ok = !x_a7n;
            4'b0001: a7_ok = !x_a7p;
            default: a7_ok = 1'b1;
        endcase
    end

    assign data_ok = v6 && !k28 && v4 && a7_ok &&
                     !(mid_pos && need_neg) && !(mid_neg && need_pos);
    assign kx7     = v6 && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)) &&
                     (((ones6 == 4'd4) && (f4 == 4'b1000)) || ((ones6 == 4'd2) && (f4 == 4'b0111)));

    // Select decoded byte and flags; anything unrecognised decodes to 0
    always_comb begin
        data    = '0;
        isk     = 1'b0;
        invalid = 1'b1;
        if (data_ok) begin
            data    = {yd, x};
            invalid = 1'b0;
        end else if (kx7) begin
            data    = {3'd7, x};
            isk     = 1'b1;
            invalid = 1'b0;
        end else if (k28 && vk) begin
            data    = {yk, 5'd28};
            isk     = 1'b1;
            invalid = 1'b0;
        end
    end

    // Whole-symbol disparity check; an offending symbol resyncs RD to itself
    always_comb begin
        disperr = 1'b0;
        rd_out  = rd_in;
        if (ones10 == 4'd6) begin
            disperr = (rd_in == RD_POS);
            rd_out  = RD_POS;
        end else if (ones10 == 4'd4) begin
            disperr = (rd_in == RD_NEG);
            rd_out  = RD_NEG;
        end
    end

endmodule

// File: rtl/gtx_10x8dec_n.sv
// BYTES-lane 10b/8b decoder: optional input register, RD-chained lane
// decoders, output register and saturating error counters.
module gtx_10x8dec_n
    import gtx_8b10b_pkg::*;
#(
    parameter int BYTES   = 2,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SYM_W*BYTES-1:0]  indata,
    input  logic                    inval,
    output logic [BYTE_W*BYTES-1:0] outdata,
    output logic [BYTES-1:0]        outisk,
    output logic [BYTES-1:0]        notintable,
    output logic [BYTES-1:0]        disperror,
    output logic                    outval,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        nit_cnt,
    output logic [CNT_W-1:0]        disp_cnt
);

    logic [SYM_W*BYTES-1:0]  dec_sym;
    logic                    dec_v;
    logic [BYTE_W*BYTES-1:0] dec_data;
    logic [BYTES-1:0]        dec_isk;
    logic [BYTES-1:0]        dec_nit;
    logic [BYTES-1:0]        dec_de;
    rd_t                     rd_q;
    rd_t                     rd_chain [BYTES+1];

    generate
        if (LATENCY == 2) begin : g_inreg
            logic [SYM_W*BYTES-1:0] in_q;
            logic                   in_v;

            // Input register stage, loads only on qualified words
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_q <= '0;
                    in_v <= 1'b0;
                end else begin
                    in_v <= inval;
                    if (inval) in_q <= indata;
                end
            end

            assign dec_sym = in_q;
            assign dec_v   = in_v;
        end else begin : g_noinreg
            assign dec_sym = indata;
            assign dec_v   = inval;
        end
    endgenerate

    assign rd_chain[0] = rd_q;

    generate
        for (genvar i = 0; i < BYTES; i++) begin : g_lane
            dec_10b8b_sym u_sym (
                .symbol  (dec_sym[SYM_W*i +: SYM_W]),
                .rd_in   (rd_chain[i]),
                .data    (dec_data[BYTE_W*i +: BYTE_W]),
                .isk     (dec_isk[i]),
                .invalid (dec_nit[i]),
                .disperr (dec_de[i]),
                .rd_out  (rd_chain[i+1])
            );
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W+3:0] s;
        s = {4'b0000, a} + {{CNT_W{1'b0}}, b};
        return (s > {4'b0000, {CNT_W{1'b1}}}) ? '1 : s[CNT_W-1:0];
    endfunction

    logic [3:0] nit_inc;
    logic [3:0] de_inc;

    assign nit_inc = dec_v ? popcount(SYM_W'(dec_nit)) : '0;
    assign de_inc  = dec_v ? popcount(SYM_W'(dec_de))  : '0;

    // Output register and running disparity, advanced only on valid words
    always_ff @(posedge clk) begin
        if (rst) begin
            outdata    <= '0;
            outisk     <= '0;
            notintable <= '0;
            disperror  <= '0;
            outval     <= 1'b0;
            rd_q       <= RD_NEG;
        end else begin
            outval <= dec_v;
            if (dec_v) begin
                outdata    <= dec_data;
                outisk     <= dec_isk;
                notintable <= dec_nit;
                disperror  <= dec_de;
                rd_q       <= rd_chain[BYTES];
            end
        end
    end

    // Saturating error counters, updated together with the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            nit_cnt  <= '0;
            disp_cnt <= '0;
        end else if (cnt_clr) begin
            nit_cnt  <= CNT_W'(nit_inc);
            disp_cnt <= CNT_W'(de_inc);
        end else begin
            nit_cnt  <= sat_add(nit_cnt, nit_inc);
            disp_cnt <= sat_add(disp_cnt, de_inc);
        end
    end

endmodule

// File: tb/tb_gtx_10x8dec_n.sv
// Randomised bench for gtx_10x8dec_n. The reference decoder is built by
// running an 8b/10b encoder over every byte and K code in both disparity
// columns; the timing model is a queue of words tagged with their due cycle.
module tb_gtx_10x8dec_n;

    localparam int B  = 2;
    localparam int L  = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [10*B-1:0] indata;
    logic            inval;
    logic [8*B-1:0]  outdata;
    logic [B-1:0]    outisk, notintable, disperror;
    logic            outval;
    logic            cnt_clr;
    logic [CW-1:0]   nit_cnt, disp_cnt;

    gtx_10x8dec_n #(.BYTES(B), .LATENCY(L), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .indata(indata), .inval(inval),
        .outdata(outdata), .outisk(outisk), .notintable(notintable),
        .disperror(disperror), .outval(outval), .cnt_clr(cnt_clr),
        .nit_cnt(nit_cnt), .disp_cnt(disp_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // RD- column of the 5b/6b and 3b/4b code tables (abcdei / fghj, a or f first)
    logic [5:0] d6n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] d4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [7:0] kcodes [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                8'hF7, 8'hFB, 8'hFD, 8'hFE};

    function automatic logic [9:0] enc(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       mid;
        logic [9:0] s;
        x  = b[4:0];
        y  = b[7:5];
        c6 = (k && x == 5'd28) ? 6'b001111 : d6n[x];
        if (rd) begin
            if ($countones(c6) != 3) c6 = ~c6;
            else if (c6 == 6'b111000) c6 = 6'b000111;
        end
        mid = ($countones(c6) == 4) ? 1'b1 : ($countones(c6) == 2) ? 1'b0 : rd;
        if (k) begin
            c4 = mid ? ~k4n[y] : k4n[y];
        end else if (y == 3'd7 && ((!mid && (x == 17 || x == 18 || x == 20)) ||
                                   (mid && (x == 11 || x == 13 || x == 14)))) begin
            c4 = mid ? 4'b1000 : 4'b0111;
        end else begin
            c4 = d4n[y];
            if (mid && (y == 0 || y == 3 || y == 4 || y == 7)) c4 = ~c4;
        end
        for (int i = 0; i < 6; i++) s[i] = c6[5-i];
        for (int i = 0; i < 4; i++) s[6+i] = c4[3-i];
        return s;
    endfunction

    logic [8:0] tab [1024];
    logic       tv  [1024];

    typedef struct {
        int             due;
        logic [8*B-1:0] d;
        logic [B-1:0]   k, n, e;
    } word_t;

    word_t          q[$];
    int             cyc = 0;
    logic           m_rd = 1'b0;
    logic           e_val;
    logic [8*B-1:0] e_data;
    logic [B-1:0]   e_k, e_n, e_e;
    int             e_nit, e_disp;

    task automatic model_edge(input logic r, input logic v, input logic [10*B-1:0] d, input logic clr);
        word_t w;
        logic [9:0] code;
        int inc_n, inc_d, mx;
        mx = (1 << CW) - 1;
        cyc++;
        if (r) begin
            q.delete();
            m_rd = 1'b0;
            e_val = 0; e_data = '0; e_k = '0; e_n = '0; e_e = '0;
            e_nit = 0; e_disp = 0;
            return;
        end
        if (v) begin
            w.due = cyc + L - 1;
            for (int i = 0; i < B; i++) begin
                code = d[10*i +: 10];
                w.n[i] = !tv[code];
                w.d[8*i +: 8] = tv[code] ? tab[code][7:0] : 8'h00;
                w.k[i] = tv[code] & tab[code][8];
                w.e[i] = 1'b0;
                if ($countones(code) == 6) begin w.e[i] = m_rd;  m_rd = 1'b1; end
                else if ($countones(code) == 4) begin w.e[i] = !m_rd; m_rd = 1'b0; end
            end
            q.push_back(w);
        end
        inc_n = 0; inc_d = 0; e_val = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            w = q.pop_front();
            e_val = 1; e_data = w.d; e_k = w.k; e_n = w.n; e_e = w.e;
            inc_n = $countones(w.n);
            inc_d = $countones(w.e);
        end
        e_nit  = clr ? inc_n : ((e_nit + inc_n > mx) ? mx : e_nit + inc_n);
        e_disp = clr ? inc_d : ((e_disp + inc_d > mx) ? mx : e_disp + inc_d);
    endtask

    task automatic tick(input logic r, input logic v, input logic [10*B-1:0] d, input logic clr);
        rst = r; inval = v; indata = d; cnt_clr = clr;
        @(posedge clk);
        model_edge(r, v, d, clr);
        #1;
        check("outval", 32'(outval), 32'(e_val));
        check("outdata", 32'(outdata), 32'(e_data));
        check("outisk", 32'(outisk), 32'(e_k));
        check("notintable", 32'(notintable), 32'(e_n));
        check("disperror", 32'(disperror), 32'(e_e));
        check("nit_cnt", 32'(nit_cnt), 32'(e_nit));
        check("disp_cnt", 32'(disp_cnt), 32'(e_disp));
    endtask

    logic tx_rd = 1'b0;

    function automatic logic [9:0] gen_lane();
        int r;
        logic [9:0] c;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        b = 8'($urandom_range(0, 255));
        if (r < 70) begin
            if ($urandom_range(0, 9) == 0) c = enc(kcodes[$urandom_range(0, 11)], 1'b1, tx_rd);
            else c = enc(b, 1'b0, tx_rd);
        end else if (r < 85) begin
            c = enc(b, 1'b0, !tx_rd);
        end else begin
            c = 10'($urandom_range(0, 1023));
        end
        if ($countones(c) == 6) tx_rd = 1'b1;
        else if ($countones(c) == 4) tx_rd = 1'b0;
        return c;
    endfunction

    initial begin
        logic [10*B-1:0] w;
        for (int i = 0; i < 1024; i++) begin tab[i] = '0; tv[i] = 1'b0; end
        for (int rd = 0; rd < 2; rd++) begin
            for (int b = 0; b < 256; b++) begin
                w[9:0] = enc(8'(b), 1'b0, rd[0]);
                tab[w[9:0]] = {1'b0, 8'(b)}; tv[w[9:0]] = 1'b1;
            end
            for (int j = 0; j < 12; j++) begin
                w[9:0] = enc(kcodes[j], 1'b1, rd[0]);
                tab[w[9:0]] = {1'b1, kcodes[j]}; tv[w[9:0]] = 1'b1;
            end
        end

        // reset state
        tick(1, 0, '0, 0);
        tick(1, 0, '0, 0);
        tick(0, 0, '0, 0);

        // K28.5 pair in correct disparity order
        tick(0, 1, {10'h283, 10'h17C}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // wrong-disparity K28.5 first, then a correct stream (resync)
        tick(1, 0, '0, 0);
        tick(0, 1, {10'h17C, 10'h283}, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, {10'h17C, 10'h283}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // neutral D21.5 with toggling qualifier
        for (int i = 0; i < 8; i++) tick(0, i[0], {10'h155, 10'h155}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // invalid symbol on lane 1
        tick(0, 1, {10'h3FF, 10'h155}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // counter saturation, then clear coinciding with an invalid word
        for (int i = 0; i < 20; i++) tick(0, 1, {10'h3FF, 10'h3FF}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);
        tick(0, 1, {10'h3FF, 10'h3FF}, (L == 1));
        if (L == 2) tick(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // reset with words in flight
        tick(0, 1, {10'h283, 10'h17C}, 0);
        tick(0, 1, {10'h283, 10'h17C}, 0);
        tick(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);
        tick(0, 1, {10'h283, 10'h17C}, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);

        // randomised traffic
        tx_rd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic r, v, clr;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < B; i++) w[10*i +: 10] = gen_lane();
            if (r) tx_rd = 1'b0;
            tick(r, v, w, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gtx_10x8dec_n.md
Name: gtx_10x8dec_n

Overview:
Parametrised successor of the 2-byte SATA 10b/8b decoder. It decodes BYTES 10-bit symbols per clock using a logic-based decoder with no RAM tables. It tracks running disparity across all lanes, resynchronises disparity after an error, and keeps saturating error counters. It sits between the GTX RX data path (after comma alignment) and the SATA link layer, and adds a valid qualifier and a selectable pipeline depth.

Parameters:
BYTES, 2, symbols per word (1..4); lane 0 = indata[9:0], earliest in time.
LATENCY, 2, inval->outval delay in clocks (1 or 2); 1 = output register only, 2 = input and output registers.
CNT_W, 16, width of each error counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
indata  in  10*BYTES  encoded symbols; per lane bit0 = a, bit1 = b, bit2 = c, bit3 = d, bit4 = e, bit5 = i, bit6 = f, bit7 = g, bit8 = h, bit9 = j.
inval  in  1  indata qualifier.
outdata  out  8*BYTES  decoded bytes HGFEDCBA per lane.
outisk  out  BYTES  control-character flag per lane.
notintable  out  BYTES  symbol is not a valid 10b code.
disperror  out  BYTES  running-disparity violation per lane.
outval  out  1  qualifier for all outputs.
cnt_clr  in  1  synchronous clear of both counters.
nit_cnt  out  CNT_W  saturating count of lanes with notintable.
disp_cnt  out  CNT_W  saturating count of lanes with disperror.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Running disparity (RD) = negative.
  - Pipeline valid bits are cleared.
  - Reset takes priority over inval and cnt_clr.
- Latency: outputs appear exactly LATENCY clocks after the inval cycle. outval mirrors inval delayed by LATENCY.
- Registers advance only when the stage valid is set. While outval = 0, outputs hold their last value.
- Per-lane decode (sub-module):
  - 5b/6b and 3b/4b decode per IEEE 802.3 clause 36.
  - K codes: K28.0 through K28.7, K23.7, K27.7, K29.7, K30.7 set isk = 1.
  - Invalid symbols give notintable = 1, outdata lane = 8'h00, isk = 0.
- Disparity per lane, processed in order lane 0 .. BYTES-1, chained within one cycle:
  - Ones count 6 (positive symbol): disperror = 1 if incoming RD is positive; new RD = positive.
  - Ones count 4 (negative symbol): disperror = 1 if incoming RD is negative; new RD = negative.
  - Ones count 5: neutral; RD unchanged; no disperror (this includes the 111000/000111 subblocks).
  - Any other ones count: the symbol is notintable; RD unchanged; disperror = 0.
  - Resync: after a disperror, RD takes the value implied by the offending symbol. A single bad symbol therefore flags exactly once.
- RD register:
  - Updates only on valid cycles, to the RD after the last lane.
  - inval = 0 leaves RD unchanged.
- Counters:
  - On each outval cycle, add popcount(notintable) to nit_cnt and popcount(disperror) to disp_cnt.
  - Both saturate at 2^CNT_W - 1; saturation is sticky until cleared.
  - cnt_clr together with an error in the same cycle: counter = that cycle's increment.
- Reset mid-stream: in-flight words are discarded; no outval pulses for them.

Decomposition:
- Shared package gtx_8b10b_pkg:
  - K-code constants (K28_5 = 10'h17C RD-, 10'h283 RD+).
  - Lane width constants 10 and 8.
  - Popcount function.
- Sub-module dec_10b8b_sym: combinational single-symbol decoder.
  - Inputs: symbol, incoming RD.
  - Outputs: data, isk, invalid, disperr, outgoing RD.
- gtx_10x8dec_n instantiates BYTES copies chained on RD, plus the pipeline and counters.

Test Plan:
1. BYTES=2, LATENCY=2: after reset, indata = {10'h283, 10'h17C}, inval = 1 for one cycle -> 2 clocks later outval = 1, outdata = 16'hBCBC, outisk = 2'b11, disperror = 2'b00, RD = negative.
2. After reset, indata lane0 = 10'h283 (K28.5 RD+ while RD-) -> disperror = 2'b01, disp_cnt = 1. The following correct RD- K28.5 sequence produces no further errors (resync).
3. Lane0 = 10'h155 (D21.5, neutral) in every position, inval toggling 1/0 -> outdata lanes = 8'hB5, RD unchanged, outval pattern equals inval delayed by 2.
4. Lane1 = 10'h3FF -> notintable = 2'b10, outdata[15:8] = 8'h00, nit_cnt increments by 1, RD unchanged.
5. CNT_W = 4, 20 consecutive invalid two-lane words -> nit_cnt saturates at 15. Asserting cnt_clr with an invalid word -> next value = 2.
6. rst asserted for one cycle while two valid words are in flight -> no outval for those words, all outputs 0, RD negative afterwards.
